// File: rtl/rns_fwd_encoder.sv
// rtl/rns_fwd_encoder.sv - bit-serial signed binary to 8-digit residue converter (Horner reduction)
// Optional build macro RNS_ENC_RADIX4_EN: consume two magnitude bits per RUN cycle.
module rns_fwd_encoder #(
  parameter int          DATA_WIDTH = 48,
  parameter logic [17:0] MOD_0      = 18'd177147,
  parameter logic [17:0] MOD_1      = 18'd78125,
  parameter logic [17:0] MOD_2      = 18'd131072,
  parameter logic [17:0] MOD_3      = 18'd117649,
  parameter logic [17:0] MOD_4      = 18'd161051,
  parameter logic [17:0] MOD_5      = 18'd28561,
  parameter logic [17:0] MOD_6      = 18'd83521,
  parameter logic [17:0] MOD_7      = 18'd130321
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [17:0]           dig_out_0,
  output logic [17:0]           dig_out_1,
  output logic [17:0]           dig_out_2,
  output logic [17:0]           dig_out_3,
  output logic [17:0]           dig_out_4,
  output logic [17:0]           dig_out_5,
  output logic [17:0]           dig_out_6,
  output logic [17:0]           dig_out_7,
  output logic [1:0]            sign_out
);

`ifdef RNS_ENC_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CYCLES = DATA_WIDTH / STEP;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam logic [17:0] MODS [8] = '{MOD_0, MOD_1, MOD_2, MOD_3, MOD_4, MOD_5, MOD_6, MOD_7};

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mag;
  logic                  neg;
  logic                  zero;
  logic [17:0]           r     [8];
  logic [17:0]           r_nxt [8];
  logic [17:0]           dig   [8];

  // Shifting the accumulator left and appending the new bits is 2^STEP*r + bits.
  function automatic logic [17:0] horner_step(input logic [17:0] acc,
                                              input logic [STEP-1:0] bits,
                                              input logic [17:0] m);
`ifdef RNS_ENC_RADIX4_EN
    logic [19:0] t, m1, m2, m3;
    t  = {acc, bits};
    m1 = {2'b00, m};
    m2 = {1'b0, m, 1'b0};
    m3 = m1 + m2;
    if (t >= m3)      t = t - m3;
    else if (t >= m2) t = t - m2;
    else if (t >= m1) t = t - m1;
    return t[17:0];
`else
    logic [18:0] t;
    t = {acc, bits};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[17:0];
`endif
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      r_nxt[k] = horner_step(r[k], mag[DATA_WIDTH-1 -: STEP], MODS[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      mag       <= '0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      sign_out  <= 2'd0;
      for (int k = 0; k < 8; k++) begin
        r[k]   <= '0;
        dig[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg      <= bin_in[DATA_WIDTH-1];
            // Negating the most negative value wraps to 2^(DATA_WIDTH-1), which is the true magnitude.
            mag      <= bin_in[DATA_WIDTH-1] ? -bin_in : bin_in;
            zero     <= (bin_in == '0);
            cnt      <= '0;
            in_ready <= 1'b0;
            for (int k = 0; k < 8; k++) r[k] <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < 8; k++) r[k] <= r_nxt[k];
          mag <= mag << STEP;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(CYCLES - 1)) state <= FINAL;
        end
        FINAL: begin
          for (int k = 0; k < 8; k++) begin
            dig[k] <= (neg && r[k] != '0) ? MODS[k] - r[k] : r[k];
          end
          sign_out  <= zero ? 2'd2 : (neg ? 2'd1 : 2'd0);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dig_out_0 = dig[0];
  assign dig_out_1 = dig[1];
  assign dig_out_2 = dig[2];
  assign dig_out_3 = dig[3];
  assign dig_out_4 = dig[4];
  assign dig_out_5 = dig[5];
  assign dig_out_6 = dig[6];
  assign dig_out_7 = dig[7];

endmodule

// File: doc/rns_fwd_encoder.md
# rns_fwd_encoder

Bit-serial forward converter from signed two's-complement binary to the 8-digit residue representation.
- Sits at the front of the error-correcting arithmetic pipeline and produces the eight 18-bit residue digits plus 2-bit sign code consumed by the subtract/correct stages.
- Computes all eight residues in parallel by Horner reduction, one input bit per clock (two with the radix-4 option).
- Uses a valid/ready handshake on both sides.

## Interface
Parameters:
- DATA_WIDTH, 48: width of signed binary input; must be even.
- MOD_0 … MOD_7, 177147, 78125, 131072, 117649, 161051, 28561, 83521, 130321: pairwise-coprime digit moduli, each < 2^18.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  bin_in holds a value to encode.
- in_ready  out  1  block can accept; high only in IDLE.
- bin_in  in  DATA_WIDTH  signed two's-complement operand.
- out_valid  out  1  digits/sign valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- dig_out_0_ … dig_out_7_  out  18 each  residue digit k, always < MOD_k.
- sign_out  out  2  sign code: 0 = positive, 1 = negative, 2 = zero; 3 never driven.

## Operation
- Reset: state IDLE, in_ready=1, out_valid=0, all dig_out=0, sign_out=0, bit counter=0. Reset mid-conversion aborts and discards the operation; no partial result is ever presented.
- FSM states: IDLE → RUN → FINAL → DONE → IDLE.
- IDLE, in_valid&in_ready:
  - latch neg = bin_in[MSB] and mag = |bin_in|, DATA_WIDTH bits unsigned; −2^(DATA_WIDTH−1) yields mag = 2^(DATA_WIDTH−1) exactly;
  - clear all residue accumulators r_k; counter=0; go to RUN.
- RUN, per cycle, for each k: take b = next mag bit, MSB first; t = 2·r_k + b (19-bit); r_k ← (t ≥ MOD_k) ? t − MOD_k : t. Counter increments; after DATA_WIDTH bits go to FINAL.
- FINAL, register outputs and go to DONE:
  - zero = (mag == 0); sign_out = zero ? 2 : (neg ? 1 : 0);
  - dig_out_k = (neg && r_k ≠ 0) ? MOD_k − r_k : r_k, i.e. the residue of the signed value.
- DONE: outputs held stable while out_ready=0. On out_valid&out_ready go to IDLE; dig_out/sign_out keep their last value, out_valid drops.
- in_valid is ignored outside IDLE; bin_in is sampled only on the accept edge.

## Timing
- Accept edge T. out_valid is high after edge T+DATA_WIDTH+1 (49 cycles at default).
- Result handshake edge H: in_ready is high after H, so the next accept is at H+1 at earliest.
- Minimum issue interval: DATA_WIDTH+3 cycles.
- Critical path per digit: one 19-bit add plus one compare/subtract. No multipliers.

## Configuration
- RNS_ENC_RADIX4_EN defined: RUN consumes two bits per cycle.
  - t = 4·r_k + 2·b1 + b0 (20-bit), reduced by up to three conditional subtractions of MOD_k, done as a compare against 1·, 2· and 3·MOD_k;
  - RUN lasts DATA_WIDTH/2 cycles; latency DATA_WIDTH/2+1.
- Not defined: radix-2 operation as described above. Digit results are identical in both modes.

## Test plan
- bin_in=0 → all digits 0, sign_out=2, out_valid after exactly 49 cycles (25 with RNS_ENC_RADIX4_EN).
- bin_in=1 → all digits 1, sign_out=0; bin_in=−1 → digits 177146, 78124, 131071, 117648, 161050, 28560, 83520, 130320, sign_out=1.
- bin_in=177147 → dig0=0, dig1=20897, dig2=46075, sign_out=0; bin_in=−2^47 → dig2=0, sign_out=1, remaining digits checked against a software model.
- Backpressure: out_ready held low 10 cycles in DONE → outputs and out_valid stable, in_ready=0, second in_valid ignored; after release, the next operand is accepted the cycle after the result handshake.
- Reset asserted at RUN cycle 20 → next cycle IDLE, out_valid=0, digits 0; a fresh operand then encodes correctly.
- 1000 random signed operands with random in_valid/out_ready gaps → all digits and sign match the reference model, no result lost or duplicated.
